// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK controller with HALT and handshake stalls.
// Define SEQ_PERF_CNT_EN to build the saturating retired/stall performance counters.
module multicycle_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       op_code,
    input  logic             instr_valid,
    input  logic             mem_ready,
    input  logic             resume,
    output logic             pc_en,
    output logic             ir_load,
    output logic             alu_en,
    output logic             mem_write_en,
    output logic             data_write_en,
    output logic             data_read_en,
    output logic             illegal_op,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEM       = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP     = 3'd0,
        CLS_ALU     = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_LOAD    = 3'd3,
        CLS_HALT    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } cls_t;

    function automatic cls_t decode_class(input logic [3:0] op);
        cls_t c;
        case (op)
            4'b0000:                            c = CLS_NOP;
            4'b0001, 4'b0010, 4'b0011,
            4'b1000, 4'b1001, 4'b1010,
            4'b1011, 4'b1100, 4'b1101:          c = CLS_ALU;
            4'b0100:                            c = CLS_STORE;
            4'b0101:                            c = CLS_LOAD;
            4'b1111:                            c = CLS_HALT;
            default:                            c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

    state_t state_q, state_d;
    cls_t   cls_q, cls_d;
    cls_t   dec_cls_s;

    // The class is only trusted from op_code while in DECODE; later stages use cls_q.
    assign dec_cls_s = decode_class(op_code);

    // State and latched-class registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            cls_q   <= CLS_NOP;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        case (state_q)
            ST_FETCH: begin
                if (instr_valid) begin
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                cls_d = dec_cls_s;
                case (dec_cls_s)
                    CLS_ALU, CLS_STORE, CLS_LOAD: state_d = ST_EXECUTE;
                    CLS_HALT:                     state_d = ST_HALT;
                    default:                      state_d = ST_FETCH;
                endcase
            end
            ST_EXECUTE: begin
                if (cls_q == CLS_ALU) begin
                    state_d = ST_WRITEBACK;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_MEM: begin
                if (!mem_ready) begin
                    state_d = ST_MEM;
                end else if (cls_q == CLS_LOAD) begin
                    state_d = ST_WRITEBACK;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_WRITEBACK: state_d = ST_FETCH;
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Strobes decode from the state register so an async reset drops them at once.
    always_comb begin
        pc_en         = 1'b0;
        ir_load       = 1'b0;
        alu_en        = 1'b0;
        mem_write_en  = 1'b0;
        data_write_en = 1'b0;
        data_read_en  = 1'b0;
        illegal_op    = 1'b0;
        halted        = 1'b0;
        case (state_q)
            ST_FETCH: begin
                pc_en   = instr_valid;
                ir_load = instr_valid;
            end
            ST_DECODE:    illegal_op    = (dec_cls_s == CLS_ILLEGAL);
            ST_EXECUTE:   alu_en        = 1'b1;
            ST_MEM: begin
                data_write_en = (cls_q == CLS_STORE);
                data_read_en  = (cls_q == CLS_LOAD);
            end
            ST_WRITEBACK: mem_write_en  = 1'b1;
            ST_HALT:      halted        = 1'b1;
            default:      halted        = 1'b0;
        endcase
    end

    assign state = state_q;

`ifdef SEQ_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             retire_s;
    logic             stall_s;
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Retire on the cycle that completes an instruction; HALT retires as it is entered.
    always_comb begin
        retire_s = 1'b0;
        stall_s  = 1'b0;
        case (state_q)
            ST_FETCH:     stall_s  = !instr_valid;
            ST_DECODE:    retire_s = (dec_cls_s == CLS_NOP) || (dec_cls_s == CLS_HALT);
            ST_MEM: begin
                stall_s  = !mem_ready;
                retire_s = mem_ready && (cls_q == CLS_STORE);
            end
            ST_WRITEBACK: retire_s = 1'b1;
            default:      retire_s = 1'b0;
        endcase
    end

    // Saturating increments.
    always_comb begin
        retired_cnt_d = (retire_s && (retired_cnt_q != CNT_MAX)) ? retired_cnt_q + CNT_ONE : retired_cnt_q;
        stall_cnt_d   = (stall_s && (stall_cnt_q != CNT_MAX)) ? stall_cnt_q + CNT_ONE : stall_cnt_q;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign retired_cnt = retired_cnt_q;
    assign stall_cnt   = stall_cnt_q;
`else
    assign retired_cnt = '0;
    assign stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: instruction-level model pushes per-cycle
// expected outputs; a negedge monitor pops and compares.
module tb_multicycle_sequencer;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    localparam logic [7:0] F_NONE = 8'b0000_0000;
    localparam logic [7:0] F_PCIR = 8'b1100_0000;
    localparam logic [7:0] F_ALU  = 8'b0010_0000;
    localparam logic [7:0] F_MWE  = 8'b0001_0000;
    localparam logic [7:0] F_DWE  = 8'b0000_1000;
    localparam logic [7:0] F_DRE  = 8'b0000_0100;
    localparam logic [7:0] F_ILL  = 8'b0000_0010;
    localparam logic [7:0] F_HLT  = 8'b0000_0001;

    localparam int C_NOP = 0, C_ALU = 1, C_ST = 2, C_LD = 3, C_HALT = 4, C_ILL = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    op_code = 4'h0;
    logic          instr_valid = 1'b0;
    logic          mem_ready = 1'b0;
    logic          resume = 1'b0;
    logic          pc_en, ir_load, alu_en, mem_write_en;
    logic          data_write_en, data_read_en, illegal_op, halted;
    logic [2:0]    state;
    logic [CW-1:0] retired_cnt, stall_cnt;

    multicycle_sequencer #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .op_code(op_code), .instr_valid(instr_valid),
        .mem_ready(mem_ready), .resume(resume), .pc_en(pc_en), .ir_load(ir_load),
        .alu_en(alu_en), .mem_write_en(mem_write_en), .data_write_en(data_write_en),
        .data_read_en(data_read_en), .illegal_op(illegal_op), .halted(halted),
        .state(state), .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    st;
        logic [7:0]    flags;
        logic [CW-1:0] ret;
        logic [CW-1:0] stl;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_a, mon_e;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int   m_ret = 0;
    int   m_stl = 0;
    int   cyc = 0;

    function automatic int cls(input logic [3:0] op);
        if (op == 4'd0) return C_NOP;
        if (op == 4'd15) return C_HALT;
        if (op == 4'd4) return C_ST;
        if (op == 4'd5) return C_LD;
        if (op == 4'd6 || op == 4'd7 || op == 4'd14) return C_ILL;
        return C_ALU;
    endfunction

    function automatic obs_t mk(input logic [2:0] st, input logic [7:0] f);
        obs_t o;
        o.st    = st;
        o.flags = f;
`ifdef SEQ_PERF_CNT_EN
        o.ret   = CW'(m_ret);
        o.stl   = CW'(m_stl);
`else
        o.ret   = '0;
        o.stl   = '0;
`endif
        return o;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom);
    endfunction

    task automatic inc_ret();
        if (m_ret < CMAX) m_ret++;
    endtask

    task automatic inc_stl();
        if (m_stl < CMAX) m_stl++;
    endtask

    // Drive one cycle's inputs right after the edge and record what should be seen.
    task automatic step(input logic iv, input logic [3:0] op, input logic mr, input logic rs, input obs_t e);
        instr_valid = iv;
        op_code     = op;
        mem_ready   = mr;
        resume      = rs;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One instruction: fw fetch waits, mw memory waits, hw cycles spent halted.
    task automatic run_instr(input logic [3:0] op, input int fw, input int mw, input int hw);
        int c;
        logic [7:0] mf;
        c = cls(op);
        for (int i = 0; i < fw; i++) begin
            step(1'b0, rop(), rb(), rb(), mk(3'd0, F_NONE));
            inc_stl();
        end
        step(1'b1, rop(), rb(), rb(), mk(3'd0, F_PCIR));
        step(rb(), op, rb(), rb(), mk(3'd1, (c == C_ILL) ? F_ILL : F_NONE));
        if (c == C_NOP || c == C_HALT) inc_ret();
        if (c == C_HALT) begin
            for (int i = 0; i < hw - 1; i++) step(rb(), rop(), rb(), 1'b0, mk(3'd5, F_HLT));
            step(rb(), rop(), rb(), 1'b1, mk(3'd5, F_HLT));
        end else if (c == C_ALU) begin
            step(rb(), rop(), rb(), rb(), mk(3'd2, F_ALU));
            step(rb(), rop(), rb(), rb(), mk(3'd4, F_MWE));
            inc_ret();
        end else if (c == C_ST || c == C_LD) begin
            mf = (c == C_ST) ? F_DWE : F_DRE;
            step(rb(), rop(), rb(), rb(), mk(3'd2, F_ALU));
            for (int i = 0; i < mw; i++) begin
                step(rb(), rop(), 1'b0, rb(), mk(3'd3, mf));
                inc_stl();
            end
            step(rb(), rop(), 1'b1, rb(), mk(3'd3, mf));
            if (c == C_ST) begin
                inc_ret();
            end else begin
                step(rb(), rop(), rb(), rb(), mk(3'd4, F_MWE));
                inc_ret();
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_a = {state, pc_en, ir_load, alu_en, mem_write_en, data_write_en,
                     data_read_en, illegal_op, halted, retired_cnt, stall_cnt};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard cycle %0d: got output %h with no expected entry", cyc, mon_a);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_a !== mon_e) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got st=%0d flags=%b ret=%0d stl=%0d, expected st=%0d flags=%b ret=%0d stl=%0d",
                             cyc, mon_a.st, mon_a.flags, mon_a.ret, mon_a.stl,
                             mon_e.st, mon_e.flags, mon_e.ret, mon_e.stl);
                end
            end
            cyc++;
        end
    end

    initial begin
        #3;
        checks++;
        if (state !== 3'd0 || {pc_en, ir_load, alu_en, mem_write_en, data_write_en, data_read_en, illegal_op, halted} !== 8'h00
            || retired_cnt !== '0 || stall_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: got st=%0d ret=%0d stl=%0d, expected st=0 ret=0 stl=0 and no strobes",
                     state, retired_cnt, stall_cnt);
        end
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        run_instr(4'b0001, 0, 0, 1);
        run_instr(4'b0100, 0, 3, 1);
        run_instr(4'b0101, 0, 0, 1);
        run_instr(4'b0110, 0, 0, 1);
        run_instr(4'b0000, 0, 0, 1);
        run_instr(4'b1111, 0, 0, 10);
        for (int n = 0; n < 150; n++) begin
            run_instr(rop(), $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(1, 4));
        end

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end

        // Store into MEM, then hit reset between edges.
        step(1'b1, rop(), rb(), rb(), mk(3'd0, F_PCIR));
        step(rb(), 4'b0100, rb(), rb(), mk(3'd1, F_NONE));
        step(rb(), rop(), rb(), rb(), mk(3'd2, F_ALU));
        mem_ready = 1'b0;
        exp_q.push_back(mk(3'd3, F_DWE));
        #6;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        checks++;
        if (data_write_en !== 1'b0 || state !== 3'd0 || retired_cnt !== '0 || stall_cnt !== '0) begin
            errors++;
            $display("FAIL async_reset: got dwe=%b st=%0d ret=%0d stl=%0d, expected dwe=0 st=0 ret=0 stl=0",
                     data_write_en, state, retired_cnt, stall_cnt);
        end
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        instr_valid = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || retired_cnt !== '0 || stall_cnt !== '0 || data_write_en !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got st=%0d ret=%0d stl=%0d dwe=%b, expected st=0 ret=0 stl=0 dwe=0",
                     state, retired_cnt, stall_cnt, data_write_en);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle sequencing controller for the 4-bit-opcode processor datapath. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK. It gates PC advance, IR load, ALU enable, register-file write and data-memory read/write into single, well-defined cycles, and stalls on instruction and data memory handshakes. It sits between the instruction register / opcode decode and the datapath enables.

## Interface
- CNT_W, 16, width of the performance counters (saturating)
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- op_code  in  4  opcode field of the instruction register; valid from DECODE onward
- instr_valid  in  1  instruction memory has valid data this cycle
- mem_ready  in  1  data memory completes the current access this cycle
- resume  in  1  leave HALT
- pc_en  out  1  advance PC
- ir_load  out  1  load instruction register
- alu_en  out  1  ALU operand/result capture
- mem_write_en  out  1  register-file write strobe
- data_write_en  out  1  data-memory write strobe
- data_read_en  out  1  data-memory read strobe
- illegal_op  out  1  one-cycle pulse on undefined opcode
- halted  out  1  sequencer is in HALT
- state  out  3  current state encoding, for debug
- retired_cnt  out  CNT_W  instructions retired
- stall_cnt  out  CNT_W  cycles spent waiting on instr_valid/mem_ready

## Operation
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5. Encodings 6 and 7 are unreachable and recover to FETCH next cycle.
- Opcode classes are latched into an internal register in DECODE; later op_code changes are ignored until the next DECODE.
  - ALU: 0001, 0010, 0011, 1000–1101.
  - STORE: 0100.
  - LOAD: 0101.
  - NOP: 0000.
  - HALT: 1111.
  - ILLEGAL: 0110, 0111, 1110.
- Transitions:
  - FETCH: goes to DECODE when instr_valid=1, otherwise stays.
  - DECODE: ALU/STORE/LOAD go to EXECUTE; NOP/ILLEGAL go to FETCH; HALT goes to HALT.
  - EXECUTE: ALU goes to WRITEBACK; STORE/LOAD go to MEM.
  - MEM: waits until mem_ready=1. Then STORE goes to FETCH and LOAD goes to WRITEBACK.
  - WRITEBACK: goes to FETCH.
  - HALT: goes to FETCH when resume=1, otherwise stays.
- Outputs are Moore, decoded from the state register and latched class:
  - pc_en and ir_load: 1 only in FETCH with instr_valid=1.
  - alu_en: 1 in EXECUTE.
  - data_write_en: 1 in MEM for STORE, held until mem_ready.
  - data_read_en: 1 in MEM for LOAD, held until mem_ready.
  - mem_write_en: 1 in WRITEBACK.
  - illegal_op: 1 in DECODE for ILLEGAL.
  - halted: 1 in HALT.
- At most one of mem_write_en, data_write_en, data_read_en is high in any cycle.
- retired_cnt increments by 1 on leaving DECODE (NOP), MEM (STORE), WRITEBACK (ALU/LOAD) or on entering HALT. ILLEGAL does not retire.
- stall_cnt increments in every FETCH cycle with instr_valid=0 and every MEM cycle with mem_ready=0.
- Both counters saturate at 2^CNT_W−1.

## Timing
- Reset values: state=FETCH, latched class=NOP, counters=0. All strobes, illegal_op and halted are 0, except that pc_en and ir_load follow instr_valid in FETCH.
- Reset is asynchronous mid-instruction. Any in-flight strobe drops immediately, with no partial write completion guaranteed.
- Zero-wait latencies, FETCH to next FETCH:
  - NOP/ILLEGAL: 2 cycles.
  - ALU: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds 1.
- mem_ready is sampled only in MEM and ignored elsewhere. instr_valid is ignored outside FETCH.
- resume=1 in the same cycle HALT is entered has no effect; HALT lasts at least 1 cycle.
- A counter at saturation stays at saturation while its increment condition persists.

## Configuration
- SEQ_PERF_CNT_EN defined: retired_cnt and stall_cnt are implemented as above.
- SEQ_PERF_CNT_EN undefined: both ports are driven constant 0, no counter flops are inferred, and all other behaviour is identical.

## Test plan
- Reset release, instr_valid=1, op_code=0001: pc_en/ir_load high at cycle 0, alu_en at cycle 2, mem_write_en at cycle 3, FETCH again at cycle 4; retired_cnt=1.
- op_code=0100, mem_ready low for 3 MEM cycles: data_write_en high for 4 consecutive cycles, never mem_write_en; stall_cnt=3, retired_cnt=1.
- op_code=0101, mem_ready=1: data_read_en at cycle 3, mem_write_en at cycle 4, next FETCH at cycle 5.
- op_code=0110, then 0000: illegal_op pulses exactly one cycle; 2-cycle FETCH–DECODE–FETCH each; retired_cnt increments only for 0000.
- op_code=1111: halted=1 and state=5 held for 10 cycles with no strobes; resume=1 gives FETCH next cycle.
- rst_n asserted mid-MEM of a STORE: data_write_en falls without waiting for a clock edge; after release, state=FETCH and counters=0. Repeat with SEQ_PERF_CNT_EN undefined: counters read 0 throughout.
